ram_writer: RTL and testbench



---
 rtl/vga_pkg.sv | 25 ++
 rtl/byte_packer.sv | 59 +++++
 rtl/ram_writer.sv | 103 ++++++++++
 tb/tb_ram_writer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Brief    : Frame geometry and writer state shared by the frame-buffer
//            writer and reader.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int H_VISIBLE  = 480;
    localparam int V_VISIBLE  = 360;
    localparam int BPP        = 24;
    localparam int FRAME_BITS = H_VISIBLE * V_VISIBLE * BPP;

    function automatic int frame_words(input int width);
        return FRAME_BITS / width;
    endfunction

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } writer_state_t;

endpackage
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : byte_packer
// Brief    : Packs bytes big-endian into a RAM_WIDTH-bit word; the completed
//            word is presented combinationally alongside its last byte.
// Revision : 1.0 - initial release
// ============================================================================
module byte_packer #(
    parameter int RAM_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           i_byte,
    input  logic                 i_valid,
    input  logic                 i_clear,
    output logic [RAM_WIDTH-1:0] o_word,
    output logic                 o_word_valid
);

    localparam int c_BPW      = RAM_WIDTH / 8;
    localparam int c_CNT_BITS = (c_BPW > 1) ? $clog2(c_BPW) : 1;
    localparam logic [c_CNT_BITS-1:0] c_LAST = c_CNT_BITS'(c_BPW - 1);

    logic [c_CNT_BITS-1:0] r_byte_cnt;

    assign o_word_valid = i_valid && !i_clear && (r_byte_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_byte_cnt <= '0;
        end else if (o_word_valid) begin
            r_byte_cnt <= '0;
        end else if (i_valid) begin
            r_byte_cnt <= r_byte_cnt + c_CNT_BITS'(1);
        end
    end

    generate
        if (c_BPW == 1) begin : g_single
            assign o_word = i_byte;
        end else begin : g_multi
            // Earlier bytes sit above the incoming one, so the first byte
            // ends up in the top lane once the word completes.
            logic [RAM_WIDTH-9:0] r_shift;

            assign o_word = {r_shift, i_byte};

            always_ff @(posedge clk) begin
                if (rst || i_clear || o_word_valid) begin
                    r_shift <= '0;
                end else if (i_valid) begin
                    r_shift <= o_word[RAM_WIDTH-9:0];
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/ram_writer.sv
`default_nettype none
// ============================================================================
// Module   : ram_writer
// Brief    : Packs the UART byte stream into words and writes them to
//            sequential frame-buffer addresses, one frame per frame_sync.
// Revision : 1.0 - initial release
// ============================================================================
module ram_writer
    import vga_pkg::*;
#(
    parameter int RAM_WIDTH   = 32,
    parameter int FRAME_WORDS = frame_words(RAM_WIDTH),
    parameter int ADDR_BITS   = $clog2(FRAME_WORDS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_sync,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 wr_en,
    output logic [ADDR_BITS-1:0] wr_addr,
    output logic [RAM_WIDTH-1:0] wr_data,
    output logic                 busy,
    output logic                 frame_done
);

    localparam logic [ADDR_BITS-1:0] c_LAST_WORD = ADDR_BITS'(FRAME_WORDS - 1);

    writer_state_t          r_state;
    writer_state_t          w_state_nxt;
    logic [ADDR_BITS-1:0]   r_word_cnt;
    logic                   r_wr_en;
    logic [ADDR_BITS-1:0]   r_wr_addr;
    logic [RAM_WIDTH-1:0]   r_wr_data;
    logic                   r_frame_done;
    logic                   w_accept;
    logic                   w_word_valid;
    logic                   w_last_word;
    logic [RAM_WIDTH-1:0]   w_word;

    // A byte arriving with frame_sync belongs to the aborted frame.
    assign w_accept    = rx_valid && (r_state == RECV) && !frame_sync;
    assign w_last_word = w_word_valid && (r_word_cnt == c_LAST_WORD);

    byte_packer #(
        .RAM_WIDTH (RAM_WIDTH)
    ) u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_byte       (rx_data),
        .i_valid      (w_accept),
        .i_clear      (frame_sync),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (frame_sync) w_state_nxt = RECV;
            RECV:    if (w_last_word) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_cnt   <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_wr_en      <= w_word_valid;
            r_frame_done <= w_last_word;
            if (w_word_valid) begin
                r_wr_addr <= r_word_cnt;
                r_wr_data <= w_word;
            end
            if (frame_sync) begin
                r_word_cnt <= '0;
            end else if (w_word_valid) begin
                r_word_cnt <= w_last_word ? '0 : r_word_cnt + ADDR_BITS'(1);
            end
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign frame_done = r_frame_done;
    assign busy       = (r_state == RECV);

endmodule
`default_nettype wire

// File: tb/tb_ram_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_writer
// Brief    : Scoreboard bench for ram_writer at the default frame size and
//            with a four-word frame, both driven by the same byte stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_writer;

    typedef struct {
        int          addr;
        logic [31:0] data;
        bit          done;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        frame_sync;
    logic [7:0]  rx_data;
    logic        rx_valid;

    logic        wr_en_b, busy_b, frame_done_b;
    logic [16:0] wr_addr_b;
    logic [31:0] wr_data_b;
    logic        wr_en_s, busy_s, frame_done_s;
    logic [1:0]  wr_addr_s;
    logic [31:0] wr_data_s;

    int          n_checks = 0;
    int          n_fail   = 0;

    exp_t        q_b[$];
    exp_t        q_s[$];

    int          fw [2] = '{129600, 4};
    bit          in_frame [2];
    int          bcnt [2];
    int          wcnt [2];
    logic [31:0] shf [2];

    ram_writer dut_b (
        .clk        (clk),
        .rst        (rst),
        .frame_sync (frame_sync),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .wr_en      (wr_en_b),
        .wr_addr    (wr_addr_b),
        .wr_data    (wr_data_b),
        .busy       (busy_b),
        .frame_done (frame_done_b)
    );

    ram_writer #(
        .FRAME_WORDS (4)
    ) dut_s (
        .clk        (clk),
        .rst        (rst),
        .frame_sync (frame_sync),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .wr_en      (wr_en_s),
        .wr_addr    (wr_addr_s),
        .wr_data    (wr_data_s),
        .busy       (busy_s),
        .frame_done (frame_done_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus and advance the reference model.
    task automatic tick(input logic r, input logic s, input logic v, input logic [7:0] d);
        exp_t e;
        @(negedge clk);
        rst        = r;
        frame_sync = s;
        rx_valid   = v;
        rx_data    = d;
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                in_frame[k] = 1'b0;
                bcnt[k]     = 0;
                wcnt[k]     = 0;
            end else if (s) begin
                in_frame[k] = 1'b1;
                bcnt[k]     = 0;
                wcnt[k]     = 0;
            end else if (v && in_frame[k]) begin
                shf[k]  = {shf[k][23:0], d};
                bcnt[k] = bcnt[k] + 1;
                if (bcnt[k] == 4) begin
                    e.addr = wcnt[k];
                    e.data = shf[k];
                    e.done = (wcnt[k] == fw[k] - 1);
                    if (k == 0) q_b.push_back(e);
                    else        q_s.push_back(e);
                    bcnt[k] = 0;
                    if (e.done) begin
                        wcnt[k]     = 0;
                        in_frame[k] = 1'b0;
                    end else begin
                        wcnt[k] = wcnt[k] + 1;
                    end
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (wr_en_b === 1'b1) begin
            if (q_b.size() == 0) begin
                check("big_unexpected_write", {15'd0, wr_addr_b, wr_data_b}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = q_b.pop_front();
                check("big_addr", 64'(wr_addr_b), 64'(e.addr));
                check("big_data", 64'(wr_data_b), 64'(e.data));
                check("big_done", 64'(frame_done_b), 64'(e.done));
            end
        end else if (frame_done_b === 1'b1) begin
            check("big_done_without_write", 64'(frame_done_b), 64'd0);
        end
    end

    always @(negedge clk) begin : mon_s
        exp_t e;
        if (wr_en_s === 1'b1) begin
            if (q_s.size() == 0) begin
                check("small_unexpected_write", {30'd0, wr_addr_s, wr_data_s}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = q_s.pop_front();
                check("small_addr", 64'(wr_addr_s), 64'(e.addr));
                check("small_data", 64'(wr_data_s), 64'(e.data));
                check("small_done", 64'(frame_done_s), 64'(e.done));
            end
        end else if (frame_done_s === 1'b1) begin
            check("small_done_without_write", 64'(frame_done_s), 64'd0);
        end
    end

    initial begin
        rst        = 1'b1;
        frame_sync = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        for (int k = 0; k < 2; k++) begin
            in_frame[k] = 1'b0;
            bcnt[k]     = 0;
            wcnt[k]     = 0;
            shf[k]      = '0;
        end

        tick(1'b1, 1'b0, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 1'b0, 8'h00);
        check("rst_wr_en",      64'(wr_en_b),      64'd0);
        check("rst_wr_addr",    64'(wr_addr_b),    64'd0);
        check("rst_wr_data",    64'(wr_data_b),    64'd0);
        check("rst_busy",       64'(busy_b),       64'd0);
        check("rst_frame_done", 64'(frame_done_b), 64'd0);
        check("rst_busy_small", 64'(busy_s),       64'd0);

        // Bytes before any frame_sync are ignored.
        tick(1'b0, 1'b0, 1'b1, 8'h55);
        tick(1'b0, 1'b0, 1'b1, 8'h66);
        idle(2);
        check("pre_sync_busy", 64'(busy_b), 64'd0);

        // First word, then a fresh frame with two back-to-back words.
        tick(1'b0, 1'b1, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 1'b1, 8'h11);
        check("sync_busy", 64'(busy_b), 64'd1);
        tick(1'b0, 1'b0, 1'b1, 8'h22);
        tick(1'b0, 1'b0, 1'b1, 8'h33);
        tick(1'b0, 1'b0, 1'b1, 8'h44);
        idle(2);
        check("word0_busy", 64'(busy_b), 64'd1);

        tick(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 1; i <= 8; i++) tick(1'b0, 1'b0, 1'b1, 8'(i));
        idle(2);

        // A byte coincident with frame_sync is dropped.
        tick(1'b0, 1'b1, 1'b1, 8'hAA);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b1, 8'(8'hB1 + i));
        idle(2);

        // Full four-word frame on the small instance, then a trailing word.
        tick(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) tick(1'b0, 1'b0, 1'b1, 8'(8'h80 + i));
        idle(2);
        check("frame_end_busy_small", 64'(busy_s), 64'd0);
        check("frame_end_busy_big",   64'(busy_b), 64'd1);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b1, 8'(8'hF0 + i));
        idle(2);

        // Abort two bytes into word 5; the next word restarts at address 0.
        tick(1'b0, 1'b0, 1'b1, 8'hC1);
        tick(1'b0, 1'b0, 1'b1, 8'hC2);
        tick(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b1, 8'(8'hD1 + i));
        idle(2);

        // Sparse random traffic across a frame restart.
        tick(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 80; i++)
            tick(1'b0, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
        idle(3);

        // Reset between the third and fourth byte of a word.
        tick(1'b0, 1'b1, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 1'b1, 8'hE1);
        tick(1'b0, 1'b0, 1'b1, 8'hE2);
        tick(1'b0, 1'b0, 1'b1, 8'hE3);
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 1'b1, 8'hE4);
        check("midrst_wr_en",      64'(wr_en_b),      64'd0);
        check("midrst_wr_addr",    64'(wr_addr_b),    64'd0);
        check("midrst_wr_data",    64'(wr_data_b),    64'd0);
        check("midrst_busy",       64'(busy_b),       64'd0);
        check("midrst_frame_done", 64'(frame_done_b), 64'd0);
        check("midrst_data_small", 64'(wr_data_s),    64'd0);
        idle(2);
        check("midrst_no_write", 64'(wr_en_b), 64'd0);

        idle(4);
        check("big_queue_drained",   64'(q_b.size()), 64'd0);
        check("small_queue_drained", 64'(q_s.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
